// File: rtl/fetch_queue_pkg.sv
// fetch_queue_pkg
// Shared types and constants for the instruction fetch queue.
//   NOP_INSTR       : instruction presented to decode while the queue is empty
//   fetch_entry_t   : one buffered {instr, pc} pair
//   fetch_in_type   : memory response/grant and decoder ready, bundled
//   fetch_out_type  : memory request and decoder-facing outputs, bundled
//   align_word()    : forces an address onto a 32-bit word boundary
package fetch_queue_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fetch_entry_t;

    typedef struct packed {
        logic        mem_gnt;
        logic        mem_rvalid;
        logic [31:0] mem_rdata;
        logic        out_ready;
    } fetch_in_type;

    typedef struct packed {
        logic        mem_valid;
        logic [31:0] mem_addr;
        logic        out_valid;
        logic [31:0] out_instr;
        logic [31:0] out_pc;
    } fetch_out_type;

    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// fetch_queue_if
// Bundles the instruction-memory port, the redirect request and the decoder
// handshake of the fetch queue.
//   master : the fetch queue itself (drives requests and decoder outputs)
//   slave  : the surrounding memory / decoder / redirect source
interface fetch_queue_if;

    logic        mem_valid;
    logic [31:0] mem_addr;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        redirect;
    logic [31:0] redirect_addr;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        out_ready;

    modport master (
        output mem_valid, mem_addr, out_valid, out_instr, out_pc,
        input  mem_gnt, mem_rvalid, mem_rdata, redirect, redirect_addr, out_ready
    );

    modport slave (
        input  mem_valid, mem_addr, out_valid, out_instr, out_pc,
        output mem_gnt, mem_rvalid, mem_rdata, redirect, redirect_addr, out_ready
    );

endinterface

// File: rtl/fetch_queue_fifo.sv
// fetch_fifo
// Parameterised DEPTH-entry synchronous FIFO (DEPTH a power of two).
//   clock, reset : rising-edge clock, synchronous active-high reset
//   clear        : empties the FIFO, wins over push/pop
//   push/push_data, pop : write tail / retire head (push+pop while full is legal)
//   count        : current occupancy
//   head         : data at the head entry (valid when count != 0)
module fetch_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         clear,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic [WIDTH-1:0]             head
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;

    // Next-state: pointers wrap naturally because DEPTH is a power of two.
    // When full with push and pop together, the write lands on the slot being
    // popped, which is safe since the head is read out in the same cycle.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/fetch_queue.sv
// fetch_queue
// In-order instruction fetch queue between instruction memory and decode.
// Issues word fetches, tags each grant with its PC, buffers returned words and
// hands them to the decoder one per handshake. A redirect flushes the buffer,
// restarts fetch and discards responses that are still in flight.
//   clock, reset : rising-edge clock, synchronous active-high reset
//   bus (master) : mem_valid/mem_addr/mem_gnt/mem_rvalid/mem_rdata memory port,
//                  redirect/redirect_addr, out_valid/out_instr/out_pc/out_ready
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int          DEPTH      = 4,
    parameter logic [31:0] RESET_ADDR = 32'h0
) (
    input  logic         clock,
    input  logic         reset,
    fetch_queue_if.master bus
);

    localparam int CW = $clog2(DEPTH + 1);

    fetch_in_type  fi;
    fetch_out_type fo;

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   last_pc_q, last_pc_d;
    logic [CW-1:0] drop_q, drop_d;
    logic [CW-1:0] buf_count;
    logic [CW-1:0] outstanding;
    logic [CW:0]   occupancy;
    logic [31:0]   tag_head;
    fetch_entry_t  buf_head;
    fetch_entry_t  buf_push_data;
    logic          grant;
    logic          buf_push;
    logic          buf_pop;

    assign fi = '{mem_gnt:    bus.mem_gnt,
                  mem_rvalid: bus.mem_rvalid,
                  mem_rdata:  bus.mem_rdata,
                  out_ready:  bus.out_ready};

    // Request and decoder-facing outputs. Fetch only while buffered plus
    // in-flight words leave room, which is what lets push+pop at full be legal.
    always_comb begin
        occupancy    = {1'b0, buf_count} + {1'b0, outstanding};
        fo.mem_valid = !reset && !bus.redirect && (occupancy < (CW+1)'(DEPTH));
        fo.mem_addr  = fetch_pc_q;
        fo.out_valid = (buf_count != '0);
        fo.out_instr = fo.out_valid ? buf_head.instr : NOP_INSTR;
        fo.out_pc    = fo.out_valid ? buf_head.pc    : last_pc_q;
    end

    assign grant         = fo.mem_valid && fi.mem_gnt;
    assign buf_push      = fi.mem_rvalid && (drop_q == '0) && !bus.redirect;
    assign buf_pop       = fo.out_valid && fi.out_ready && !bus.redirect;
    assign buf_push_data = '{instr: fi.mem_rdata, pc: tag_head};

    // Fetch PC, drop counter and last-popped PC. The tag FIFO count is the
    // total in flight, already including words marked for dropping, so on a
    // redirect everything in flight except a word returning right now is stale.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        drop_d     = drop_q;
        last_pc_d  = last_pc_q;
        if (bus.redirect) begin
            fetch_pc_d = align_word(bus.redirect_addr);
            drop_d     = outstanding - CW'(fi.mem_rvalid);
        end else begin
            if (grant) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
            if (fi.mem_rvalid && (drop_q != '0)) begin
                drop_d = drop_q - 1'b1;
            end
        end
        if (buf_pop) begin
            last_pc_d = buf_head.pc;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            fetch_pc_q <= RESET_ADDR;
            last_pc_q  <= RESET_ADDR;
            drop_q     <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            last_pc_q  <= last_pc_d;
            drop_q     <= drop_d;
        end
    end

    // PC tags of granted requests; every response retires one tag, stale or not.
    fetch_fifo #(.DEPTH(DEPTH), .WIDTH(32)) u_tag_fifo (
        .clock     (clock),
        .reset     (reset),
        .clear     (1'b0),
        .push      (grant),
        .push_data (fetch_pc_q),
        .pop       (fi.mem_rvalid),
        .count     (outstanding),
        .head      (tag_head)
    );

    // Buffered {instr, pc} entries waiting for the decoder.
    fetch_fifo #(.DEPTH(DEPTH), .WIDTH($bits(fetch_entry_t))) u_buf_fifo (
        .clock     (clock),
        .reset     (reset),
        .clear     (bus.redirect),
        .push      (buf_push),
        .push_data (buf_push_data),
        .pop       (buf_pop),
        .count     (buf_count),
        .head      (buf_head)
    );

    assign bus.mem_valid = fo.mem_valid;
    assign bus.mem_addr  = fo.mem_addr;
    assign bus.out_valid = fo.out_valid;
    assign bus.out_instr = fo.out_instr;
    assign bus.out_pc    = fo.out_pc;

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue
// Directed and randomised bench for fetch_queue. A small in-order memory model
// answers granted requests after a chosen latency, and a scoreboard of expected
// buffer contents predicts mem_valid, mem_addr and the decoder outputs.
module tb_fetch_queue;
    import fetch_queue_pkg::*;

    localparam int          DEPTH      = 4;
    localparam logic [31:0] RESET_ADDR = 32'h0;

    typedef struct {
        logic [31:0] addr;
        int          readyCycle;
    } req_t;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } ent_t;

    logic clock = 1'b0;
    logic reset;

    fetch_queue_if bus();

    fetch_queue #(.DEPTH(DEPTH), .RESET_ADDR(RESET_ADDR)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int          assertCount = 0;
    int          failCount   = 0;
    int          cycle       = 0;
    req_t        pending[$];
    ent_t        expBuf[$];
    logic [31:0] modelPc;
    logic [31:0] lastPc;
    int          modelDrop;
    logic        gntEn, rspEn, readyEn, redirEn;
    logic [31:0] redirAddr;
    int          latency;

    // Instruction memory contents: two fixed words, then an address-derived pattern.
    function automatic logic [31:0] wordAt(input logic [31:0] addr);
        if (addr == 32'h0) return 32'h0010_0093;
        if (addr == 32'h4) return 32'h0020_0113;
        return {addr[29:0], 2'b11} ^ 32'h5a00_0000;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Holds reset for two edges, checks reset values, then releases it and
    // clears the memory model and scoreboard.
    task automatic doReset();
        reset             = 1'b1;
        gntEn             = 1'b0;
        rspEn             = 1'b0;
        readyEn           = 1'b0;
        redirEn           = 1'b0;
        redirAddr         = 32'h0;
        latency           = 1;
        bus.mem_gnt       = 1'b0;
        bus.mem_rvalid    = 1'b0;
        bus.mem_rdata     = 32'h0;
        bus.redirect      = 1'b0;
        bus.redirect_addr = 32'h0;
        bus.out_ready     = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        checkOutput("rst_mem_valid", bus.mem_valid, 1'b0);
        checkOutput("rst_mem_addr",  bus.mem_addr,  RESET_ADDR);
        checkOutput("rst_out_valid", bus.out_valid, 1'b0);
        checkOutput("rst_out_instr", bus.out_instr, 32'h0000_0013);
        checkOutput("rst_out_pc",    bus.out_pc,    RESET_ADDR);
        reset     = 1'b0;
        pending.delete();
        expBuf.delete();
        modelPc   = RESET_ADDR;
        lastPc    = RESET_ADDR;
        modelDrop = 0;
    endtask

    // One clock cycle: drive inputs, check outputs mid-cycle against the
    // scoreboard, update the memory model and scoreboard, advance the clock.
    task automatic applyStimulus();
        logic        rsp;
        logic        gnt;
        logic        pop;
        logic [31:0] rspAddr;
        logic        expValid;
        rsp = rspEn && (pending.size() != 0) && (pending[0].readyCycle <= cycle);
        rspAddr           = rsp ? pending[0].addr : 32'h0;
        bus.mem_gnt       = gntEn;
        bus.mem_rvalid    = rsp;
        bus.mem_rdata     = rsp ? wordAt(rspAddr) : 32'hdead_beef;
        bus.redirect      = redirEn;
        bus.redirect_addr = redirAddr;
        bus.out_ready     = readyEn;
        #1;
        expValid = !redirEn && ((expBuf.size() + pending.size()) < DEPTH);
        checkOutput("mem_valid", bus.mem_valid, expValid);
        checkOutput("mem_addr",  bus.mem_addr,  modelPc);
        checkOutput("out_valid", bus.out_valid, expBuf.size() != 0);
        if (expBuf.size() != 0) begin
            checkOutput("out_pc",    bus.out_pc,    expBuf[0].pc);
            checkOutput("out_instr", bus.out_instr, expBuf[0].instr);
        end else begin
            checkOutput("idle_pc",    bus.out_pc,    lastPc);
            checkOutput("idle_instr", bus.out_instr, 32'h0000_0013);
        end
        gnt = bus.mem_valid && gntEn && !redirEn;
        pop = (expBuf.size() != 0) && readyEn && !redirEn;
        if (pop) begin
            lastPc = expBuf[0].pc;
            void'(expBuf.pop_front());
        end
        if (rsp) void'(pending.pop_front());
        if (redirEn) begin
            expBuf.delete();
            modelDrop = pending.size();
            modelPc   = {redirAddr[31:2], 2'b00};
        end else if (rsp) begin
            if (modelDrop > 0) modelDrop--;
            else expBuf.push_back('{instr: wordAt(rspAddr), pc: rspAddr});
        end
        if (gnt) begin
            pending.push_back('{addr: modelPc, readyCycle: cycle + latency});
            modelPc = modelPc + 32'd4;
        end
        @(posedge clock);
        #1;
        cycle++;
    endtask

    initial begin
        int n;

        // Reset values
        doReset();

        // Streaming with k = 1: one instruction per cycle
        gntEn = 1'b1; rspEn = 1'b1; readyEn = 1'b1; latency = 1;
        applyStimulus();
        applyStimulus();
        checkOutput("t1_pc0",    bus.out_pc,    32'h0);
        checkOutput("t1_instr0", bus.out_instr, 32'h0010_0093);
        applyStimulus();
        checkOutput("t1_pc1",    bus.out_pc,    32'h4);
        checkOutput("t1_instr1", bus.out_instr, 32'h0020_0113);
        repeat (10) applyStimulus();

        // Backpressure: fill to DEPTH, head must hold, then resume
        doReset();
        gntEn = 1'b1; rspEn = 1'b1; readyEn = 1'b0; latency = 1;
        repeat (8) applyStimulus();
        checkOutput("t2_full_stall", bus.mem_valid, 1'b0);
        checkOutput("t2_head_pc",    bus.out_pc,    32'h0);
        checkOutput("t2_head_instr", bus.out_instr, 32'h0010_0093);
        readyEn = 1'b1;
        applyStimulus();
        checkOutput("t2_resume", bus.mem_valid, 1'b1);
        checkOutput("t2_next_pc", bus.out_pc, 32'h4);
        repeat (8) applyStimulus();

        // Redirect with three requests in flight
        doReset();
        gntEn = 1'b1; rspEn = 1'b0; readyEn = 1'b1; latency = 1;
        repeat (3) applyStimulus();
        redirEn = 1'b1; redirAddr = 32'h103;
        applyStimulus();
        redirEn = 1'b0; rspEn = 1'b1;
        bus.redirect = 1'b0;
        #1;
        checkOutput("t3_req_valid", bus.mem_valid, 1'b1);
        checkOutput("t3_req_addr",  bus.mem_addr,  32'h100);
        n = 0;
        while (!bus.out_valid && n < 20) begin
            applyStimulus();
            n++;
        end
        checkOutput("t3_first_valid", bus.out_valid, 1'b1);
        checkOutput("t3_first_pc",    bus.out_pc,    32'h100);
        repeat (6) applyStimulus();

        // Redirect coinciding with a response and a pop
        doReset();
        gntEn = 1'b1; rspEn = 1'b1; readyEn = 1'b1; latency = 1;
        repeat (4) applyStimulus();
        redirEn = 1'b1; redirAddr = 32'h200;
        applyStimulus();
        checkOutput("t4_empty",    bus.out_valid, 1'b0);
        checkOutput("t4_last_pc",  bus.out_pc,    32'h4);
        checkOutput("t4_nop",      bus.out_instr, 32'h0000_0013);
        redirEn = 1'b0;
        n = 0;
        while (!bus.out_valid && n < 20) begin
            applyStimulus();
            n++;
        end
        checkOutput("t4_first_valid", bus.out_valid, 1'b1);
        checkOutput("t4_first_pc",    bus.out_pc,    32'h200);
        checkOutput("t4_first_instr", bus.out_instr, 32'h5a00_0803);
        repeat (4) applyStimulus();

        // Randomised grant/latency/ready with occasional redirects
        doReset();
        rspEn = 1'b1;
        for (int i = 0; i < 10000; i++) begin
            gntEn     = ($urandom_range(0, 3) != 0);
            rspEn     = ($urandom_range(0, 3) != 0);
            readyEn   = ($urandom_range(0, 2) != 0);
            latency   = $urandom_range(1, 3);
            redirEn   = ($urandom_range(0, 99) < 3);
            redirAddr = $urandom;
            applyStimulus();
        end

        // Reset in the middle of traffic
        doReset();

        // Fetch address wraps past the top of memory
        gntEn = 1'b1; rspEn = 1'b1; readyEn = 1'b1; latency = 1;
        redirEn = 1'b1; redirAddr = 32'hffff_fffe;
        applyStimulus();
        redirEn = 1'b0;
        checkOutput("t6_addr_top", bus.mem_addr, 32'hffff_fffc);
        applyStimulus();
        checkOutput("t6_addr_wrap", bus.mem_addr, 32'h0);
        n = 0;
        while (!bus.out_valid && n < 20) begin
            applyStimulus();
            n++;
        end
        checkOutput("t6_pc_top", bus.out_pc, 32'hffff_fffc);
        applyStimulus();
        checkOutput("t6_pc_wrap", bus.out_pc, 32'h0);
        repeat (4) applyStimulus();

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
